pu_rom_arb: RTL

- Sequences and shares the 4-byte-lane instruction ROM between two requesters: instruction fetch (IF) and load/store constant-read (LS).
- Accepts one request at a time, drives the ROM read, waits the ROM latency, then returns the word or the size-extracted sub-word with a one-cycle valid pulse.
- Sits between the core fetch/LSU and the ROM byte banks.

---
 rtl/pu_rom_pkg.sv | 34 +++
 rtl/pu_rr_arb2.sv | 46 ++++
 rtl/pu_rom_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pu_rom_pkg.sv
// pu_rom_pkg: shared constants and helpers for the instruction-ROM arbiter.
//   ADDR_W_DEF    default ROM byte-address width
//   SZ_B/SZ_H/SZ_W load size encodings (3 is treated as word)
//   state_e       arbiter FSM states
//   REQ_IF/REQ_LS requester ids
//   ls_extract    zero-extending sub-word extraction for LS responses
package pu_rom_pkg;

  localparam int unsigned ADDR_W_DEF = 11;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2,
    StErr  = 2'd3
  } state_e;

  // The ROM already returns bytes starting at the requested address, so no shift.
  function automatic logic [31:0] ls_extract(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      SZ_B:    return {24'b0, d[7:0]};
      SZ_H:    return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/pu_rr_arb2.sv
// pu_rr_arb2: two-input round-robin arbiter with a one-bit pointer.
//   clk, rst         clock, synchronous active-high reset (pointer -> IF)
//   i_en             grants may only be issued while high
//   i_req_if/i_req_ls request lines
//   o_gnt_if/o_gnt_ls combinational one-hot grant
module pu_rr_arb2
  import pu_rom_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_if,
  input  logic i_req_ls,
  output logic o_gnt_if,
  output logic o_gnt_ls
);

  // Names the side that wins when both request together.
  logic r_ptr;

  always_comb begin
    o_gnt_if = 1'b0;
    o_gnt_ls = 1'b0;
    if (i_en) begin
      if (i_req_if && i_req_ls) begin
        o_gnt_if = (r_ptr == REQ_IF);
        o_gnt_ls = (r_ptr == REQ_LS);
      end else begin
        o_gnt_if = i_req_if;
        o_gnt_ls = i_req_ls;
      end
    end
  end

  // Any grant hands priority to the other side, contested or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= REQ_IF;
    end else if (o_gnt_if) begin
      r_ptr <= REQ_LS;
    end else if (o_gnt_ls) begin
      r_ptr <= REQ_IF;
    end
  end

endmodule

// File: rtl/pu_rom_arb.sv
// pu_rom_arb: shares the 4-byte-lane instruction ROM between fetch (IF) and
// load constant reads (LS). One access outstanding; grant, ROM read, wait
// ROM_LAT cycles, then a one-cycle rvalid with word or zero-extended sub-word.
// Out-of-range addresses answer with err=1 and data 0 without touching the ROM.
//   clk, rst                       clock, synchronous active-high reset
//   if_req/addr, if_gnt/rvalid/data/err   fetch port
//   ls_req/addr/size, ls_gnt/rvalid/data/err  load port
//   rom_re_out, rom_addr_out, rom_data_in    ROM interface
// Optional: define PU_ROM_ARB_IBUF_EN for a one-entry fetch buffer that lets a
// repeated fetch of the same address skip the ROM (response one cycle after grant).
module pu_rom_arb
  import pu_rom_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_in,
  input  logic [31:0]       if_addr_in,
  output logic              if_gnt_out,
  output logic              if_rvalid_out,
  output logic [31:0]       if_data_out,
  output logic              if_err_out,
  input  logic              ls_req_in,
  input  logic [31:0]       ls_addr_in,
  input  logic [1:0]        ls_size_in,
  output logic              ls_gnt_out,
  output logic              ls_rvalid_out,
  output logic [31:0]       ls_data_out,
  output logic              ls_err_out,
  output logic              rom_re_out,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [31:0]       rom_data_in
);

  state_e      r_state, w_state_nxt;
  logic        r_req;
  logic [1:0]  r_size;
  logic [1:0]  r_cnt;
  logic [31:0] r_if_data, r_ls_data;

  logic        w_en, w_gnt_if, w_gnt_ls, w_gnt;
  logic [31:0] w_addr;
  logic        w_in_range, w_hit, w_rom_re, w_resp, w_sample;

  assign w_en = (r_state == StIdle) && !rst;

  pu_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en),
    .i_req_if (if_req_in),
    .i_req_ls (ls_req_in),
    .o_gnt_if (w_gnt_if),
    .o_gnt_ls (w_gnt_ls)
  );

  assign w_gnt      = w_gnt_if | w_gnt_ls;
  assign w_addr     = w_gnt_ls ? ls_addr_in : if_addr_in;
  assign w_in_range = ((w_addr >> ADDR_W) == 32'd0);
  assign w_sample   = (r_state == StWait) && (r_cnt == 2'd0);

`ifdef PU_ROM_ARB_IBUF_EN
  logic              r_buf_vld;
  logic [ADDR_W-1:0] r_buf_tag, r_addr;
  logic [31:0]       r_buf_data;

  // Tag keeps the byte-offset bits so a misaligned fetch never aliases the buffered word.
  assign w_hit = w_gnt_if && r_buf_vld && (if_addr_in == {{(32-ADDR_W){1'b0}}, r_buf_tag});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_tag  <= '0;
      r_addr     <= '0;
      r_buf_data <= '0;
    end else begin
      if (w_gnt) r_addr <= w_addr[ADDR_W-1:0];
      if (w_sample && (r_req == REQ_IF)) begin
        r_buf_vld  <= 1'b1;
        r_buf_tag  <= r_addr;
        r_buf_data <= rom_data_in;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_gnt) begin
          if (!w_in_range) w_state_nxt = StErr;
          else if (w_hit)  w_state_nxt = StResp;
          else             w_state_nxt = StWait;
        end
      end
      StWait:  if (r_cnt == 2'd0) w_state_nxt = StResp;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Capture and response data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req     <= REQ_IF;
      r_size    <= SZ_B;
      r_cnt     <= 2'd0;
      r_if_data <= '0;
      r_ls_data <= '0;
    end else begin
      if (w_gnt) begin
        r_req  <= w_gnt_ls;
        r_size <= ls_size_in;
        r_cnt  <= 2'(ROM_LAT - 1);
        if (!w_in_range) begin
          if (w_gnt_ls) r_ls_data <= '0;
          else          r_if_data <= '0;
        end
`ifdef PU_ROM_ARB_IBUF_EN
        if (w_hit && w_in_range) r_if_data <= r_buf_data;
`endif
      end else if (w_sample) begin
        if (r_req == REQ_LS) r_ls_data <= ls_extract(rom_data_in, r_size);
        else                 r_if_data <= rom_data_in;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign w_rom_re = w_gnt && w_in_range && !w_hit;
  assign w_resp   = !rst && ((r_state == StResp) || (r_state == StErr));

  // Outputs
  always_comb begin
    if_gnt_out    = w_gnt_if;
    ls_gnt_out    = w_gnt_ls;
    rom_re_out    = w_rom_re;
    rom_addr_out  = w_rom_re ? w_addr[ADDR_W-1:0] : '0;
    if_rvalid_out = w_resp && (r_req == REQ_IF);
    ls_rvalid_out = w_resp && (r_req == REQ_LS);
    if_err_out    = if_rvalid_out && (r_state == StErr);
    ls_err_out    = ls_rvalid_out && (r_state == StErr);
    if_data_out   = rst ? 32'd0 : r_if_data;
    ls_data_out   = rst ? 32'd0 : r_ls_data;
  end

endmodule
